// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bridge and its TX FIFO.
// Contents:
//   MMIO_BASE           upper address half that selects the register window
//   mmio_reg_e          register offsets inside the window (dataadr[7:0])
//   STAT_*_BIT          bit positions inside the STATUS word
//   TX_CLR_OVF_BIT      writedata bit that turns a TXDATA write into an ovf clear
//   DEFAULT_FIFO_DEPTH  default TX FIFO depth (power of two, >= 2)
//   is_mmio()           address decode helper
package mmio_pkg;

    localparam logic [15:0] MMIO_BASE = 16'hFFFF;

    typedef enum logic [7:0] {
        REG_LED   = 8'h00,
        REG_TX    = 8'h04,
        REG_CYCLE = 8'h08,
        REG_CMP   = 8'h0C,
        REG_IRQ   = 8'h10
    } mmio_reg_e;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;

    localparam int TX_CLR_OVF_BIT = 31;

    localparam int DEFAULT_FIFO_DEPTH = 4;

    function automatic logic is_mmio(input logic [31:0] adr);
        return (adr[31:16] == MMIO_BASE);
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte-wide transmit FIFO.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset; empties the FIFO
//   push_i   write wdata_i at the tail (ignored when full unless popping)
//   pop_i    remove the head entry (ignored when empty)
//   wdata_i  byte to enqueue
//   rdata_o  head (oldest) byte; 0 while empty
//   full_o   DEPTH entries held
//   empty_o  no entries held
//   count_o  number of entries held, width log2(DEPTH)+1
module tx_fifo
    import mmio_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               wdata_i,
    output logic [7:0]               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          pop_ok_s;
    logic          push_ok_s;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == {CW{1'b0}});
    assign count_o = count_q;

    // When full, a push is only legal if the head slot is freed in the
    // same cycle; since wr_ptr==rd_ptr then, the new byte lands in the
    // slot being vacated and becomes the new tail.
    assign pop_ok_s  = pop_i && !empty_o;
    assign push_ok_s = push_i && (!full_o || pop_ok_s);

    // Head byte, forced to zero while empty so stale entries never show.
    always_comb begin
        if (empty_o) begin
            rdata_o = 8'h00;
        end else begin
            rdata_o = mem_q[rd_ptr_q];
        end
    end

    // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_ok_s && !pop_ok_s) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// Splits core data accesses between data memory and a small MMIO register
// window (LED, TX FIFO, free-running cycle counter, compare, interrupt).
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   memwrite    core store strobe
//   dataadr     core data address; upper half 0xFFFF selects MMIO
//   writedata   core store data
//   readdata    combinational load data back to the core
//   dmem_we     data memory write enable (stores outside MMIO)
//   dmem_rdata  data memory read data
//   leds        LED register
//   tx_data     TX FIFO head byte
//   tx_valid    TX FIFO non-empty
//   tx_ready    consumer takes the head byte this cycle
//   irq         sticky cycle==compare interrupt
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        dmem_we,
    input  logic [31:0] dmem_rdata,
    output logic [7:0]  leds,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    leds_q;
    logic [7:0]    leds_d;
    logic [31:0]   cycle_q;
    logic [31:0]   cycle_d;
    logic [31:0]   cmp_q;
    logic [31:0]   cmp_d;
    logic          irq_q;
    logic          irq_d;
    logic          ovf_q;
    logic          ovf_d;

    logic          mmio_sel_s;
    logic [7:0]    off_s;
    logic          reg_wr_s;
    logic          wr_led_s;
    logic          wr_tx_s;
    logic          wr_cycle_s;
    logic          wr_cmp_s;
    logic          wr_irq_s;
    logic          tx_push_s;
    logic          ovf_clr_s;
    logic          tx_pop_s;
    logic          tx_drop_s;
    logic          tx_full_s;
    logic          tx_empty_s;
    logic [CW-1:0] tx_count_s;
    logic          irq_hit_s;
    logic [31:0]   status_s;
    logic [31:0]   reg_rdata_s;
    logic          unused_adr_s;

    // Only the low byte picks the register, so the window aliases across
    // dataadr[15:8].
    assign unused_adr_s = ^dataadr[15:8];

    assign mmio_sel_s = is_mmio(dataadr);
    assign off_s      = dataadr[7:0];
    assign reg_wr_s   = memwrite && mmio_sel_s;
    assign dmem_we    = memwrite && !mmio_sel_s;

    assign wr_led_s   = reg_wr_s && (off_s == REG_LED);
    assign wr_tx_s    = reg_wr_s && (off_s == REG_TX);
    assign wr_cycle_s = reg_wr_s && (off_s == REG_CYCLE);
    assign wr_cmp_s   = reg_wr_s && (off_s == REG_CMP);
    assign wr_irq_s   = reg_wr_s && (off_s == REG_IRQ);

    // A TXDATA write with the top bit set is an ovf-clear command, not a push.
    assign tx_push_s  = wr_tx_s && !writedata[TX_CLR_OVF_BIT];
    assign ovf_clr_s  = wr_tx_s && writedata[TX_CLR_OVF_BIT];

    assign tx_valid   = (tx_count_s != {CW{1'b0}});
    assign tx_pop_s   = tx_valid && tx_ready;
    assign tx_drop_s  = tx_push_s && tx_full_s && !tx_pop_s;

    assign irq_hit_s  = (cycle_q == cmp_q) && (cmp_q != 32'h0000_0000);

    assign leds = leds_q;
    assign irq  = irq_q;

    tx_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (tx_push_s),
        .pop_i   (tx_pop_s),
        .wdata_i (writedata[7:0]),
        .rdata_o (tx_data),
        .full_o  (tx_full_s),
        .empty_o (tx_empty_s),
        .count_o (tx_count_s)
    );

    // STATUS word assembly.
    always_comb begin
        status_s                 = 32'h0000_0000;
        status_s[STAT_EMPTY_BIT] = tx_empty_s;
        status_s[STAT_FULL_BIT]  = tx_full_s;
        status_s[STAT_OVF_BIT]   = ovf_q;
    end

    // Register read mux and final load-data select.
    always_comb begin
        reg_rdata_s = 32'h0000_0000;
        case (off_s)
            REG_LED:   reg_rdata_s = {24'h00_0000, leds_q};
            REG_TX:    reg_rdata_s = status_s;
            REG_CYCLE: reg_rdata_s = cycle_q;
            REG_CMP:   reg_rdata_s = cmp_q;
            REG_IRQ:   reg_rdata_s = {31'h0000_0000, irq_q};
            default:   reg_rdata_s = 32'h0000_0000;
        endcase
        if (mmio_sel_s) begin
            readdata = reg_rdata_s;
        end else begin
            readdata = dmem_rdata;
        end
    end

    // Next-state for the register file, counter, interrupt and overflow flag.
    always_comb begin
        leds_d  = leds_q;
        cmp_d   = cmp_q;
        cycle_d = cycle_q;
        irq_d   = irq_q;
        ovf_d   = ovf_q;

        if (wr_led_s) begin
            leds_d = writedata[7:0];
        end else begin
            leds_d = leds_q;
        end

        if (wr_cmp_s) begin
            cmp_d = writedata;
        end else begin
            cmp_d = cmp_q;
        end

        // Clear beats increment; the increment wraps at 2^32.
        if (wr_cycle_s) begin
            cycle_d = 32'h0000_0000;
        end else begin
            cycle_d = cycle_q + 32'h0000_0001;
        end

        // A new match wins over a simultaneous W1C so no event is lost.
        if (irq_hit_s) begin
            irq_d = 1'b1;
        end else if (wr_irq_s && writedata[0]) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end

        if (ovf_clr_s) begin
            ovf_d = 1'b0;
        end else if (tx_drop_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Register file state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds_q  <= 8'h00;
            cycle_q <= 32'h0000_0000;
            cmp_q   <= 32'h0000_0000;
            irq_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            leds_q  <= leds_d;
            cycle_q <= cycle_d;
            cmp_q   <= cmp_d;
            irq_q   <= irq_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: a queue-based behavioural model
// tracks the register window and TX FIFO; a compare process checks every
// output against it each cycle, and directed sequences pin literal values.
module tb_mmio_bridge;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        dmem_we;
    logic [31:0] dmem_rdata;
    logic [7:0]  leds;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [7:0]  m_leds = 8'h00;
    logic [31:0] m_cyc  = 32'h0;
    logic [31:0] m_cmp  = 32'h0;
    logic        m_irq  = 1'b0;
    logic        m_ovf  = 1'b0;
    logic [7:0]  m_q[$];

    mmio_bridge #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .readdata   (readdata),
        .dmem_we    (dmem_we),
        .dmem_rdata (dmem_rdata),
        .leds       (leds),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_leds = 8'h00;
        m_cyc  = 32'h0;
        m_cmp  = 32'h0;
        m_irq  = 1'b0;
        m_ovf  = 1'b0;
        m_q.delete();
    endtask

    task automatic model_step();
        logic       mm;
        logic [7:0] off;
        logic       wr;
        logic       pop;
        logic       hit;
        int         sz;
        mm  = (dataadr[31:16] == 16'hFFFF);
        off = dataadr[7:0];
        wr  = memwrite && mm;
        sz  = m_q.size();
        pop = (sz != 0) && tx_ready;
        hit = (m_cyc == m_cmp) && (m_cmp != 32'h0);
        if (wr && off == 8'h00) m_leds = writedata[7:0];
        if (wr && off == 8'h0C) m_cmp = writedata;
        if (wr && off == 8'h08) m_cyc = 32'h0;
        else                    m_cyc = m_cyc + 32'h1;
        if (hit) m_irq = 1'b1;
        else if (wr && off == 8'h10 && writedata[0]) m_irq = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (wr && off == 8'h04) begin
            if (writedata[31])             m_ovf = 1'b0;
            else if (sz < DEPTH || pop)    m_q.push_back(writedata[7:0]);
            else                           m_ovf = 1'b1;
        end
    endtask

    function automatic logic [31:0] exp_rdata();
        if (dataadr[31:16] != 16'hFFFF) return dmem_rdata;
        case (dataadr[7:0])
            8'h00:   return {24'h0, m_leds};
            8'h04:   return {29'h0, m_ovf, (m_q.size() == DEPTH), (m_q.size() == 0)};
            8'h08:   return m_cyc;
            8'h0C:   return m_cmp;
            8'h10:   return {31'h0, m_irq};
            default: return 32'h0;
        endcase
    endfunction

    // Model update: async reset, otherwise one step per rising edge.
    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else        model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("tx_valid", {31'h0, tx_valid}, {31'h0, (m_q.size() != 0)});
            chk("tx_data", {24'h0, tx_data}, {24'h0, (m_q.size() != 0) ? m_q[0] : 8'h00});
            chk("leds", {24'h0, leds}, {24'h0, m_leds});
            chk("irq", {31'h0, irq}, {31'h0, m_irq});
            chk("dmem_we", {31'h0, dmem_we},
                {31'h0, (memwrite && dataadr[31:16] != 16'hFFFF)});
            chk("readdata", readdata, exp_rdata());
        end
    end

    task automatic idle(input int n);
        memwrite = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = adr;
        writedata = d;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] v);
        memwrite = 1'b0;
        dataadr  = adr;
        @(negedge clk);
        v = readdata;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] v;
    logic [7:0]  e36 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0]  e37 [4] = '{8'h02, 8'h03, 8'h04, 8'h66};
    logic [7:0]  offs [7] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h03};

    initial begin
        reset      = 1'b0;
        memwrite   = 1'b0;
        dataadr    = 32'hFFFF_0004;
        writedata  = 32'h0;
        dmem_rdata = 32'h0;
        tx_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_leds", {24'h0, leds}, 32'h0);
        chk("rst_txv", {31'h0, tx_valid}, 32'h0);
        chk("rst_txd", {24'h0, tx_data}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_status", readdata, 32'h1);
        reset = 1'b1;
        idle(2);

        // LED store/load
        wr(32'hFFFF_0000, 32'h0000_00A5);
        rd(32'hFFFF_0000, v);
        chk("led_rd", v, 32'h0000_00A5);
        chk("led_out", {24'h0, leds}, 32'h0000_00A5);

        // Plain memory store then load
        dmem_rdata = 32'hCAFE_0001;
        memwrite   = 1'b1;
        dataadr    = 32'h0000_0040;
        writedata  = 32'h1234_5678;
        @(negedge clk);
        chk("dmem_we_st", {31'h0, dmem_we}, 32'h1);
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        @(negedge clk);
        chk("dmem_we_ld", {31'h0, dmem_we}, 32'h0);
        chk("dmem_rd", readdata, 32'hCAFE_0001);
        @(posedge clk);
        #1;
        chk("led_keep", {24'h0, leds}, 32'h0000_00A5);

        // Overfill with consumer stalled, then drain
        tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) wr(32'hFFFF_0004, 32'(i * 8'h11));
        rd(32'hFFFF_0004, v);
        chk("stat_ovf_full", v, 32'h6);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_order", {24'h0, tx_data}, {24'h0, e36[i]});
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b0;
        rd(32'hFFFF_0004, v);
        chk("stat_ovf_empty", v, 32'h5);
        wr(32'hFFFF_0004, 32'h8000_0000);
        rd(32'hFFFF_0004, v);
        chk("stat_ovf_clr", v, 32'h1);

        // Push into a full FIFO on the same cycle as a pop
        for (int i = 1; i <= 4; i++) wr(32'hFFFF_0004, 32'(i));
        tx_ready = 1'b1;
        wr(32'hFFFF_0004, 32'h0000_0066);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("full_pushpop", {24'h0, tx_data}, {24'h0, e37[i]});
            @(posedge clk);
            #1;
        end
        rd(32'hFFFF_0004, v);
        chk("stat_no_ovf", v, 32'h1);
        tx_ready = 1'b0;

        // Timer compare interrupt
        wr(32'hFFFF_000C, 32'd20);
        wr(32'hFFFF_0008, 32'h0);
        idle(20);
        chk("irq_before", {31'h0, irq}, 32'h0);
        rd(32'hFFFF_0008, v);
        chk("cycle_20", v, 32'd20);
        chk("irq_rise", {31'h0, irq}, 32'h1);
        wr(32'hFFFF_0008, 32'h0);
        idle(20);
        wr(32'hFFFF_0010, 32'h1);
        chk("irq_set_wins", {31'h0, irq}, 32'h1);
        wr(32'hFFFF_0010, 32'h1);
        chk("irq_w1c", {31'h0, irq}, 32'h0);

        // Randomized traffic
        for (int blk = 0; blk < 15; blk++) begin
            int rdy_pct;
            rdy_pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
            for (int c = 0; c < 200; c++) begin
                logic [7:0] off;
                tx_ready   = ($urandom_range(0, 99) < rdy_pct);
                memwrite   = ($urandom_range(0, 9) < 4);
                dmem_rdata = $urandom;
                writedata  = $urandom;
                if ($urandom_range(0, 3) != 0) begin
                    off     = offs[$urandom_range(0, 6)];
                    dataadr = {16'hFFFF, 8'($urandom), off};
                    if (off == 8'h04 && $urandom_range(0, 7) != 0) writedata[31] = 1'b0;
                    if (off == 8'h0C) writedata = $urandom_range(0, 40);
                end else begin
                    dataadr = $urandom;
                    if (dataadr[31:16] == 16'hFFFF) dataadr[31] = 1'b0;
                end
                @(posedge clk);
                #1;
            end
        end

        // Reset while bytes are queued
        tx_ready = 1'b1;
        idle(8);
        tx_ready = 1'b0;
        wr(32'hFFFF_0000, 32'h0000_00FF);
        for (int i = 1; i <= 3; i++) wr(32'hFFFF_0004, 32'(i));
        chk("pre_rst_txv", {31'h0, tx_valid}, 32'h1);
        chk("pre_rst_led", {24'h0, leds}, 32'h0000_00FF);
        #1;
        reset = 1'b0;
        #1;
        chk("async_txv", {31'h0, tx_valid}, 32'h0);
        chk("async_led", {24'h0, leds}, 32'h0);
        chk("async_txd", {24'h0, tx_data}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        rd(32'hFFFF_0004, v);
        chk("post_rst_stat", v, 32'h1);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
